// File: rtl/codificador_pkg.sv
// Shared types and helpers for the one-hot to 3-bit encoder.
// The encoding is the exact inverse of the 3-to-8 line decoder.
package codificador_pkg;

  localparam int LINE_COUNT = 8;
  localparam int CODE_W     = 3;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {S_IDLE, S_SETTLE} deb_state_t;

  // Line 7 maps to code 0 and line 0 maps to code 7.
  function automatic code_t onehot_to_code(input logic [LINE_COUNT-1:0] v);
    code_t c;
    c = '0;
    for (int i = 0; i < LINE_COUNT; i++) begin
      if (v[i]) c = code_t'(LINE_COUNT - 1 - i);
    end
    return c;
  endfunction

endpackage

// File: rtl/sincronizador_antirrebote.sv
// Input synchronizer plus debounce FSM.
// Emits the accepted stable vector and a registered one-cycle accept pulse.
module sincronizador_antirrebote
  import codificador_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LINE_COUNT-1:0] lines_in,
  output logic [LINE_COUNT-1:0] stable,
  output logic                  accept,
  output deb_state_t            state
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [LINE_COUNT-1:0] sync_q [SYNC_STAGES];
  logic [LINE_COUNT-1:0] sync;
  logic [LINE_COUNT-1:0] cand, cand_n;
  logic [LINE_COUNT-1:0] stable_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  accept_n;
  deb_state_t            state_n;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= lines_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
      accept <= 1'b0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      cnt    <= cnt_n;
      stable <= stable_n;
      accept <= accept_n;
    end
  end

  always_comb begin
    state_n  = state;
    cand_n   = cand;
    cnt_n    = cnt;
    stable_n = stable;
    accept_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (sync != stable) begin
          cand_n  = sync;
          cnt_n   = CNT_W'(1);
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (sync != cand) begin
          // A bounce back to the accepted vector abandons the candidate.
          if (sync == stable) begin
            state_n = S_IDLE;
          end else begin
            cand_n = sync;
            cnt_n  = CNT_W'(1);
          end
        end else if (STABLE_CYCLES == 1 || cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          stable_n = cand;
          accept_n = 1'b1;
          state_n  = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: rtl/codificador_onehot.sv
// One-hot to 3-bit encoder with synchronized, debounced inputs,
// a single-entry valid/ready output register and sticky error flags.
module codificador_onehot
  import codificador_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LINE_COUNT-1:0] lines_in,
  output code_t                 code_out,
  output logic                  code_valid,
  input  logic                  code_ready,
  output logic                  onehot_err,
  output logic                  overrun,
  input  logic                  err_clear
);

  logic [LINE_COUNT-1:0] stable;
  logic                  accept;
  deb_state_t            deb_state;
  logic                  code_evt;
  logic                  multi_evt;

  sincronizador_antirrebote #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .lines_in(lines_in),
    .stable  (stable),
    .accept  (accept),
    .state   (deb_state)
  );

  // An all-zero vector is a release and raises neither a code nor an error.
  assign code_evt  = accept && ($countones(stable) == 1);
  assign multi_evt = accept && ($countones(stable) > 1);

  // Handshake: a code transfers on any edge where code_valid && code_ready;
  // code_out is frozen while code_valid is high and code_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out   <= '0;
      code_valid <= 1'b0;
      onehot_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (err_clear) begin
        onehot_err <= 1'b0;
        overrun    <= 1'b0;
      end
      if (code_evt) begin
        if (!code_valid || code_ready) begin
          code_out   <= onehot_to_code(stable);
          code_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (code_valid && code_ready) begin
        code_valid <= 1'b0;
      end
      if (multi_evt) onehot_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_codificador_onehot.sv
// Directed bench for codificador_onehot at default parameters.
module tb_codificador_onehot;
  import codificador_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lines_in = 8'h00;
  code_t      code_out;
  logic       code_valid;
  logic       code_ready = 1'b0;
  logic       onehot_err;
  logic       overrun;
  logic       err_clear = 1'b0;

  int checks = 0;
  int failures = 0;

  codificador_onehot #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lines_in  (lines_in),
    .code_out  (code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .onehot_err(onehot_err),
    .overrun   (overrun),
    .err_clear (err_clear)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] sweep_lines [7];
  logic [2:0] sweep_codes [7];
  int         pulses;
  int         err_seen;
  logic [2:0] got;

  initial begin
    sweep_lines = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    sweep_codes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    // Reset state
    step(2);
    check("rst_code", 8'(code_out), 8'h00);
    check("rst_valid", 8'(code_valid), 8'h00);
    check("rst_err", 8'(onehot_err), 8'h00);
    check("rst_ovr", 8'(overrun), 8'h00);
    rst_n = 1'b1;
    step(2);

    // 0x80 latency: valid exactly after the 7th edge
    lines_in = 8'h80;
    step(6);
    check("lat80_early", 8'(code_valid), 8'h00);
    step(1);
    check("lat80_valid", 8'(code_valid), 8'h01);
    check("lat80_code", 8'(code_out), 8'h00);
    code_ready = 1'b1;
    lines_in = 8'h00;
    step(1);
    check("lat80_consumed", 8'(code_valid), 8'h00);
    step(10);
    check("release_novalid", 8'(code_valid), 8'h00);

    // Sweep 0x40..0x01 with ready held high
    for (int s = 0; s < 7; s++) begin
      lines_in = sweep_lines[s];
      pulses = 0;
      got = 3'd0;
      for (int c = 0; c < 12; c++) begin
        step(1);
        if (code_valid) begin
          pulses++;
          got = code_out;
        end
      end
      check($sformatf("sweep_pulses_%0d", s), 8'(pulses), 8'd1);
      check($sformatf("sweep_code_%0d", s), 8'(got), 8'(sweep_codes[s]));
      lines_in = 8'h00;
      step(10);
    end

    // Short glitch: 3 synchronized cycles of 0x20
    lines_in = 8'h20;
    step(3);
    lines_in = 8'h00;
    pulses = 0;
    err_seen = 0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (code_valid) pulses++;
      if (onehot_err || overrun) err_seen++;
    end
    check("glitch_novalid", 8'(pulses), 8'd0);
    check("glitch_noflags", 8'(err_seen), 8'd0);

    // Multi-hot 0x18
    lines_in = 8'h18;
    step(6);
    check("multi_err_early", 8'(onehot_err), 8'h00);
    step(1);
    check("multi_err", 8'(onehot_err), 8'h01);
    check("multi_novalid", 8'(code_valid), 8'h00);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check("multi_cleared", 8'(onehot_err), 8'h00);
    lines_in = 8'h00;
    step(10);

    // Overrun: 0x04 pending, 0x02 arrives while ready low
    code_ready = 1'b0;
    lines_in = 8'h04;
    step(7);
    check("ovr_valid", 8'(code_valid), 8'h01);
    check("ovr_code5", 8'(code_out), 8'h05);
    lines_in = 8'h00;
    step(10);
    lines_in = 8'h02;
    step(7);
    check("ovr_flag", 8'(overrun), 8'h01);
    check("ovr_code_held", 8'(code_out), 8'h05);
    check("ovr_valid_held", 8'(code_valid), 8'h01);
    code_ready = 1'b1;
    step(1);
    check("ovr_handoff_valid", 8'(code_valid), 8'h00);
    check("ovr_handoff_code", 8'(code_out), 8'h05);
    code_ready = 1'b0;
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check("ovr_cleared", 8'(overrun), 8'h00);
    lines_in = 8'h00;
    step(10);

    // Same-edge hand-off and reload
    lines_in = 8'h40;
    step(7);
    check("same_first", 8'(code_out), 8'h01);
    lines_in = 8'h00;
    step(10);
    lines_in = 8'h08;
    step(6);
    check("same_pending", 8'(code_out), 8'h01);
    code_ready = 1'b1;
    step(1);
    check("same_valid", 8'(code_valid), 8'h01);
    check("same_newcode", 8'(code_out), 8'h04);
    check("same_noovr", 8'(overrun), 8'h00);
    step(1);
    check("same_drained", 8'(code_valid), 8'h00);
    code_ready = 1'b0;
    lines_in = 8'h00;
    step(10);

    // Reset mid-operation with 0x01 held
    lines_in = 8'h01;
    step(7);
    check("rst2_pre_valid", 8'(code_valid), 8'h01);
    rst_n = 1'b0;
    #1;
    check("rst2_valid", 8'(code_valid), 8'h00);
    check("rst2_code", 8'(code_out), 8'h00);
    step(2);
    rst_n = 1'b1;
    step(6);
    check("rst2_early", 8'(code_valid), 8'h00);
    step(1);
    check("rst2_valid_after", 8'(code_valid), 8'h01);
    check("rst2_code7", 8'(code_out), 8'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
